// File: rtl/bus_arb_pkg.sv
// Shared types and sizing helpers for the bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  // Watchdog counter width; covers the full TIMEOUT_CYC range of 1..65535.
  localparam int WD_W = 16;

  function automatic int own_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotating priority encoder: the first set request at or after
// 'start' (wrapping) wins; start = 0 degenerates to fixed lowest-index priority.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = own_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  // Walk the ring once from 'start'; 'found' blocks every later candidate.
  always_comb begin
    int   k;
    logic take;
    logic found;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    k      = 0;
    take   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k         = (int'(start) + i) % N;
      take      = req[k] & ~found;
      onehot[k] = take;
      idx       = take ? W'(k) : idx;
      found     = found | take;
    end
    any = found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-owner bus arbiter (round-robin or fixed priority) with turnaround cycle.
// Optional watchdog revoke is compiled in when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int  N_MASTERS   = 8,
  parameter int  RR_MODE     = 1,
  parameter int  TIMEOUT_CYC = 255,
  localparam int OWN_W       = own_width(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N_MASTERS-1:0] DMA,
  output logic [N_MASTERS-1:0] grant,
  output logic                 BUS_req,
  input  logic                 BUS_ready,
  output logic [OWN_W-1:0]     owner_id,
  output logic                 bus_err,
  output logic [OWN_W-1:0]     err_id
);

  arb_state_t             state_r;
  arb_state_t             state_s;
  logic [N_MASTERS-1:0]   grant_r;
  logic [N_MASTERS-1:0]   grant_s;
  logic                   bus_req_r;
  logic [OWN_W-1:0]       owner_id_r;
  logic [OWN_W-1:0]       owner_id_s;
  logic [OWN_W-1:0]       last_owner_r;
  logic [OWN_W-1:0]       last_owner_s;
  logic [OWN_W-1:0]       start_s;
  logic [N_MASTERS-1:0]   mask_s;
  logic [N_MASTERS-1:0]   eligible_s;
  logic [N_MASTERS-1:0]   win_onehot_s;
  logic [OWN_W-1:0]       win_idx_s;
  logic                   win_any_s;
  logic                   owner_req_s;
  logic                   revoke_s;

  assign eligible_s  = DMA & ~mask_s;
  assign owner_req_s = DMA[owner_id_r];

  // Search origin: one past the last owner in round-robin, index 0 otherwise.
  always_comb begin
    if (RR_MODE != 0) begin
      start_s = (last_owner_r == OWN_W'(N_MASTERS - 1)) ? '0 : last_owner_r + OWN_W'(1);
    end else begin
      start_s = '0;
    end
  end

  rr_pick #(
    .N (N_MASTERS),
    .W (OWN_W)
  ) u_pick (
    .req    (eligible_s),
    .start  (start_s),
    .onehot (win_onehot_s),
    .idx    (win_idx_s),
    .any    (win_any_s)
  );

  // Next-state and next-grant decode; the owner is never preempted.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    owner_id_s   = owner_id_r;
    last_owner_s = last_owner_r;
    case (state_r)
      ST_IDLE: begin
        if (win_any_s) begin
          state_s      = ST_OWNED;
          grant_s      = win_onehot_s;
          owner_id_s   = win_idx_s;
          last_owner_s = win_idx_s;
        end else begin
          grant_s    = '0;
          owner_id_s = '0;
        end
      end
      ST_OWNED: begin
        if (!owner_req_s || revoke_s) begin
          state_s    = ST_TURN;
          grant_s    = '0;
          owner_id_s = '0;
        end else begin
          grant_s    = grant_r;
          owner_id_s = owner_id_r;
        end
      end
      ST_TURN: begin
        state_s    = ST_IDLE;
        grant_s    = '0;
        owner_id_s = '0;
      end
      default: begin
        state_s    = ST_IDLE;
        grant_s    = '0;
        owner_id_s = '0;
      end
    endcase
  end

  // Arbitration state and registered bus outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      bus_req_r    <= 1'b0;
      owner_id_r   <= '0;
      last_owner_r <= OWN_W'(N_MASTERS - 1);
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      bus_req_r    <= |grant_s;
      owner_id_r   <= owner_id_s;
      last_owner_r <= last_owner_s;
    end
  end

  assign grant    = grant_r;
  assign BUS_req  = bus_req_r;
  assign owner_id = owner_id_r;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [WD_W-1:0]      wd_cnt_r;
  logic [N_MASTERS-1:0] mask_r;
  logic                 bus_err_r;
  logic [OWN_W-1:0]     err_id_r;

  // The edge on which the counter would reach TIMEOUT_CYC is the revoke edge.
  assign revoke_s = (state_r == ST_OWNED) && owner_req_s && !BUS_ready &&
                    (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));
  assign mask_s   = mask_r;

  // Watchdog count, revoke mask and error reporting.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wd_cnt_r  <= '0;
      mask_r    <= '0;
      bus_err_r <= 1'b0;
      err_id_r  <= '0;
    end else begin
      if ((state_r == ST_OWNED) && !BUS_ready) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end else begin
        wd_cnt_r <= '0;
      end
      // A mask bit survives only while its request stays asserted.
      mask_r    <= (mask_r & DMA) | (revoke_s ? grant_r : '0);
      bus_err_r <= revoke_s;
      err_id_r  <= revoke_s ? owner_id_r : err_id_r;
    end
  end

  assign bus_err = bus_err_r;
  assign err_id  = err_id_r;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  logic unused_ready;

  assign unused_ready = BUS_ready;
  assign revoke_s     = 1'b0;
  assign mask_s       = '0;
  assign bus_err      = 1'b0;
  assign err_id       = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected grant/error events with their cycle,
// a negedge monitor pops and compares whenever a grant changes or bus_err fires.
module tb_bus_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  typedef struct {
    int           dut;
    int           cyc;
    logic [N-1:0] grant;
    logic [W-1:0] owner;
  } gnt_exp_t;

  typedef struct {
    int           dut;
    int           cyc;
    logic [W-1:0] id;
  } err_exp_t;

  logic         clk = 1'b0;
  logic         clr;
  logic         BUS_ready;
  logic [N-1:0] dma_a, dma_b, grant_a, grant_b;
  logic         bus_req_a, bus_req_b, err_a, err_b;
  logic [W-1:0] owner_a, owner_b, err_id_a, err_id_b;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  gnt_exp_t exp_q[$];
  err_exp_t err_q[$];

  bus_arbiter #(.N_MASTERS(N), .RR_MODE(1), .TIMEOUT_CYC(4)) u_rr (
    .clk(clk), .clr(clr), .DMA(dma_a), .grant(grant_a), .BUS_req(bus_req_a),
    .BUS_ready(BUS_ready), .owner_id(owner_a), .bus_err(err_a), .err_id(err_id_a)
  );

  bus_arbiter #(.N_MASTERS(N), .RR_MODE(0), .TIMEOUT_CYC(4)) u_fp (
    .clk(clk), .clr(clr), .DMA(dma_b), .grant(grant_b), .BUS_req(bus_req_b),
    .BUS_ready(BUS_ready), .owner_id(owner_b), .bus_err(err_b), .err_id(err_id_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_g(input int d, input int c, input logic [N-1:0] g, input int o);
    gnt_exp_t e;
    e.dut = d; e.cyc = c; e.grant = g; e.owner = W'(o);
    exp_q.push_back(e);
  endtask

  task automatic push_e(input int d, input int c, input int id);
    err_exp_t e;
    e.dut = d; e.cyc = c; e.id = W'(id);
    err_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic grant_event(input int d, input logic [N-1:0] g, input logic [W-1:0] o,
                             input logic br);
    gnt_exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL grant_evt: got dut%0d cyc %0d grant %0h owner %0d, required no change",
               d, cyc, g, o);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.cyc != cyc || e.grant !== g || e.owner !== o ||
          br !== (e.grant != '0)) begin
        miscompares++;
        $display("FAIL grant_evt: got dut%0d cyc %0d grant %0h owner %0d req %0b, required dut%0d cyc %0d grant %0h owner %0d req %0b",
                 d, cyc, g, o, br, e.dut, e.cyc, e.grant, e.owner, (e.grant != '0));
      end
    end
  endtask

  task automatic err_event(input int d, input logic [W-1:0] id);
    err_exp_t e;
    vectors++;
    if (err_q.size() == 0) begin
      miscompares++;
      $display("FAIL err_evt: got dut%0d cyc %0d err_id %0d, required no bus_err", d, cyc, id);
    end else begin
      e = err_q.pop_front();
      if (e.dut != d || e.cyc != cyc || e.id !== id) begin
        miscompares++;
        $display("FAIL err_evt: got dut%0d cyc %0d err_id %0d, required dut%0d cyc %0d err_id %0d",
                 d, cyc, id, e.dut, e.cyc, e.id);
      end
    end
  endtask

  // Monitor: sample away from the rising edge, compare on every output event.
  logic [N-1:0] prev_a = '0;
  logic [N-1:0] prev_b = '0;
  always @(negedge clk) begin
    check("onehot_a", 32'($onehot0(grant_a)), 32'd1);
    check("onehot_b", 32'($onehot0(grant_b)), 32'd1);
    if (grant_a !== prev_a) begin
      grant_event(0, grant_a, owner_a, bus_req_a);
      prev_a = grant_a;
    end
    if (grant_b !== prev_b) begin
      grant_event(1, grant_b, owner_b, bus_req_b);
      prev_b = grant_b;
    end
    if (err_a !== 1'b0) err_event(0, err_id_a);
    if (err_b !== 1'b0) err_event(1, err_id_b);
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no end of stimulus, required completion");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int c, g;
    clr = 1'b1; BUS_ready = 1'b0; dma_a = '0; dma_b = '0;
    wait_cyc(2);
    check("rst_grant_a",   32'(grant_a),   32'h0);
    check("rst_busreq_a",  32'(bus_req_a), 32'h0);
    check("rst_owner_a",   32'(owner_a),   32'h0);
    check("rst_err_a",     32'(err_a),     32'h0);
    check("rst_errid_a",   32'(err_id_a),  32'h0);
    check("rst_grant_b",   32'(grant_b),   32'h0);
    clr = 1'b0;

    // Single request, release, turnaround.
    wait_cyc(cyc + 1); c = cyc;
    dma_a = 8'h04; push_g(0, c + 1, 8'h04, 2);
    wait_cyc(c + 3); dma_a = 8'h00; push_g(0, c + 4, 8'h00, 0);

    // Reset while idle so round-robin restarts at index 0.
    wait_cyc(c + 7);
    clr = 1'b1; #1;
    check("idle_rst_grant", 32'(grant_a), 32'h0);
    #1 clr = 1'b0;

    // Round-robin fairness with all masters requesting.
    wait_cyc(cyc + 1); c = cyc;
    dma_a = 8'hFF; push_g(0, c + 1, 8'h01, 0);
    for (int i = 0; i < 9; i++) begin
      g = c + 1 + 5 * i;
      wait_cyc(g + 2);
      if (i < 8) dma_a[i % 8] = 1'b0;
      else       dma_a = 8'h00;
      push_g(0, g + 3, 8'h00, 0);
      if (i < 8) begin
        wait_cyc(g + 3);
        dma_a[i % 8] = 1'b1;
        push_g(0, g + 5, 8'(1 << ((i + 1) % 8)), (i + 1) % 8);
      end
    end

    // Owner drops on the same edge another master rises.
    wait_cyc(cyc + 3); c = cyc;
    dma_a = 8'h02; push_g(0, c + 1, 8'h02, 1);
    wait_cyc(c + 2); dma_a = 8'h08; push_g(0, c + 3, 8'h00, 0); push_g(0, c + 5, 8'h08, 3);
    wait_cyc(c + 6); dma_a = 8'h00; push_g(0, c + 7, 8'h00, 0);

    // Asynchronous reset mid-transfer (search wraps from 4 to 1 first).
    wait_cyc(c + 10); c = cyc;
    dma_a = 8'h02; push_g(0, c + 1, 8'h02, 1);
    wait_cyc(c + 2);
    clr = 1'b1; push_g(0, c + 2, 8'h00, 0); #1;
    check("async_grant",  32'(grant_a),   32'h0);
    check("async_busreq", 32'(bus_req_a), 32'h0);
    check("async_owner",  32'(owner_a),   32'h0);
    dma_a = 8'h01;
    #1 clr = 1'b0; push_g(0, c + 3, 8'h01, 0);
    wait_cyc(c + 4); dma_a = 8'h00; push_g(0, c + 5, 8'h00, 0);

    // Fixed priority: master 1 keeps winning over master 3.
    wait_cyc(c + 8); c = cyc;
    dma_b = 8'h0A; push_g(1, c + 1, 8'h02, 1);
    for (int i = 0; i < 3; i++) begin
      g = c + 1 + 5 * i;
      wait_cyc(g + 2);
      dma_b = 8'h08; push_g(1, g + 3, 8'h00, 0);
      if (i < 2) begin
        wait_cyc(g + 3);
        dma_b = 8'h0A; push_g(1, g + 5, 8'h02, 1);
      end else begin
        push_g(1, g + 5, 8'h08, 3);
        wait_cyc(g + 6);
        dma_b = 8'h00; push_g(1, g + 7, 8'h00, 0);
      end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog revoke, mask until release, BUS_ready restarting the count.
    wait_cyc(cyc + 3); c = cyc;
    dma_a = 8'h20;
    push_g(0, c + 1, 8'h20, 5); push_g(0, c + 5, 8'h00, 0); push_e(0, c + 5, 5);
    push_g(0, c + 11, 8'h20, 5); push_g(0, c + 18, 8'h00, 0); push_e(0, c + 18, 5);
    wait_cyc(c + 8);  check("err_id_held", 32'(err_id_a), 32'd5);
    wait_cyc(c + 9);  dma_a = 8'h00;
    wait_cyc(c + 10); dma_a = 8'h20;
    wait_cyc(c + 13); BUS_ready = 1'b1;
    wait_cyc(c + 14); BUS_ready = 1'b0;
    wait_cyc(c + 19); dma_a = 8'h00;
`else
    check("no_wd_err",   32'(err_a),    32'h0);
    check("no_wd_errid", 32'(err_id_a), 32'h0);
`endif

    wait_cyc(cyc + 6);
    while (exp_q.size() > 0) begin
      gnt_exp_t e;
      e = exp_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL grant_missing: got no event, required dut%0d cyc %0d grant %0h", e.dut, e.cyc, e.grant);
    end
    while (err_q.size() > 0) begin
      err_exp_t e;
      e = err_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL err_missing: got no bus_err, required dut%0d cyc %0d err_id %0d", e.dut, e.cyc, e.id);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 8: number of requesting masters, legal range 2..16.
REQ-002 Parameter RR_MODE, default 1: 1 selects round-robin arbitration, 0 selects fixed priority (index 0 highest).
REQ-003 Parameter TIMEOUT_CYC, default 255: watchdog limit in cycles, legal range 1..65535; used only with BUS_ARB_TIMEOUT_EN.
REQ-004 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port clr  input  1  reset; asynchronous, active-high.
REQ-006 Port DMA  input  N_MASTERS  per-master bus request, level-held.
REQ-007 Port grant  output  N_MASTERS  one-hot-or-zero bus ownership, registered.
REQ-008 Port BUS_req  output  1  high whenever any grant bit is high, registered.
REQ-009 Port BUS_ready  input  1  slave completion pulse from memory.
REQ-010 Port owner_id  output  OWN_W  index of the current owner (OWN_W = clog2(N_MASTERS)); 0 when idle.
REQ-011 Port bus_err  output  1  one-cycle pulse on watchdog revoke.
REQ-012 Port err_id  output  OWN_W  index of the revoked master, held until the next error.

Function
REQ-013 FSM states: IDLE, OWNED, TURN.
REQ-014 IDLE: if DMA (after masking) is nonzero at an edge, the winner's grant bit, owner_id and BUS_req go high after that edge; next state OWNED.
REQ-015 OWNED: grant held unchanged while DMA[owner] is 1; other requests are ignored (no preemption).
REQ-016 OWNED: DMA[owner] sampled 0 -> grant and BUS_req go 0 after that edge; next state TURN.
REQ-017 TURN: lasts exactly one cycle with grant = 0 (bus turnaround); next state IDLE; requests seen in TURN are not granted until IDLE.
REQ-018 Result: minimum request-to-grant latency is 1 cycle; minimum gap between consecutive grants is 2 cycles.
REQ-019 Round-robin: search starts at (last_owner + 1) mod N_MASTERS and wraps; last_owner updates on each grant; after reset last_owner = N_MASTERS-1, so index 0 is searched first.
REQ-020 Fixed priority: the lowest set index wins; last_owner is not used.
REQ-021 At most one grant bit is ever high; grant never changes in the same cycle a different master's bit rises.
REQ-022 A BUS_ready pulse in IDLE or TURN is ignored.

Reset
REQ-023 clr high asynchronously forces: state IDLE, grant 0, BUS_req 0, owner_id 0, bus_err 0, err_id 0, last_owner N_MASTERS-1, watchdog counter 0, mask 0.
REQ-024 clr asserted while in OWNED drops the grant immediately, without waiting for an edge; after clr falls, arbitration resumes from IDLE at the next edge.

Configuration
REQ-025 Macro BUS_ARB_TIMEOUT_EN: when defined, a watchdog is compiled in; when undefined, bus_err and err_id are tied to 0 and no counter exists.
REQ-026 Watchdog counter: cleared on entry to OWNED and on each BUS_ready; increments on every other OWNED cycle.
REQ-027 When the counter reaches TIMEOUT_CYC: grant is dropped after that edge, bus_err pulses for one cycle, err_id = owner, next state TURN, and mask[owner] is set.
REQ-028 A masked master is excluded from arbitration until its DMA bit is sampled 0, which clears its mask bit.

Structure
REQ-029 Package bus_arb_pkg holds the state encoding enum and the OWN_W width function/constant.
REQ-030 Sub-module rr_pick: combinational rotating priority encoder (request vector, start index) -> one-hot winner plus index; it is instantiated once.

Verification
REQ-031 Single request: reset, then DMA=8'h04 -> grant=8'h04 and owner_id=2 one cycle later; DMA drops -> grant=0 next cycle, then one TURN cycle.
REQ-032 Round-robin fairness: N=8, DMA=8'hFF held, each owner drops after 3 cycles and re-raises -> grant order 0,1,2,...,7,0 with 2-cycle gaps.
REQ-033 Fixed priority (RR_MODE=0): DMA=8'h0A re-raised continuously -> master 1 always wins; master 3 granted only when DMA[1]=0.
REQ-034 Timeout (macro on, TIMEOUT_CYC=4): owner 5 holds DMA with no BUS_ready -> grant revoked after 4 cycles, bus_err pulses once, err_id=5; DMA[5] not re-granted until it drops.
REQ-035 Async reset mid-transfer: clr pulses between edges while grant=8'h02 -> grant=0 immediately; after release, DMA=8'h01 -> grant=8'h01 (index 0 searched first).
REQ-036 Simultaneous events: DMA[owner] falls on the same edge that another DMA bit rises -> no overlap, TURN observed, then new grant.
